// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM state codes and requester port indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam int unsigned PORT_I = 0;  // instruction-cache refill path
    localparam int unsigned PORT_D = 1;  // dcache_top

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the arbiter. MEM_ARB_RR_EN selects round-robin on the
// last-served pointer; otherwise the dcache port always wins a tie.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

`ifndef MEM_ARB_RR_EN
    logic w_unused_last;
    assign w_unused_last = i_last;
`endif

    // NOTE: o_gnt is assigned a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = 2'b00;
`ifdef MEM_ARB_RR_EN
            // The port not served last wins the tie.
            if (i_last == 1'(PORT_D)) o_gnt[PORT_I] = 1'b1;
            else                      o_gnt[PORT_D] = 1'b1;
`else
            o_gnt[PORT_D] = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 256-bit memory port between icache refill (port 0) and dcache (port 1).
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 1.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_data_o,
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [1:0]        gnt_o,
    output logic              err_o
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_req;
    logic [1:0] w_pick;
    logic       w_last;
    logic       w_drop;
    logic       r_err;

    assign w_req = {p1_enable_i, p0_enable_i};

`ifdef MEM_ARB_RR_EN
    logic r_last;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_last <= 1'(PORT_I);
        end else if (mem_ack_i && r_state == ST_GNT0) begin
            r_last <= 1'(PORT_I);
        end else if (mem_ack_i && r_state == ST_GNT1) begin
            r_last <= 1'(PORT_D);
        end
    end

    assign w_last = r_last;
`else
    assign w_last = 1'b0;
`endif

    mem_arb_pick u_pick (
        .i_req  (w_req),
        .i_last (w_last),
        .o_gnt  (w_pick)
    );

    // NOTE: state flops use non-blocking assignment so every always_ff reads pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick[PORT_D])      w_next = ST_GNT1;
                else if (w_pick[PORT_I]) w_next = ST_GNT0;
            end
            ST_GNT0, ST_GNT1: begin
                if (mem_ack_i) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        p0_ack_o     = 1'b0;
        p1_ack_o     = 1'b0;
        gnt_o        = 2'b00;
        case (r_state)
            ST_GNT0: begin
                mem_enable_o  = 1'b1;
                mem_write_o   = p0_write_i;
                mem_addr_o    = p0_addr_i;
                mem_data_o    = p0_data_i;
                p0_ack_o      = mem_ack_i;
                gnt_o[PORT_I] = 1'b1;
            end
            ST_GNT1: begin
                mem_enable_o  = 1'b1;
                mem_write_o   = p1_write_i;
                mem_addr_o    = p1_addr_i;
                mem_data_o    = p1_data_i;
                p1_ack_o      = mem_ack_i;
                gnt_o[PORT_D] = 1'b1;
            end
            default: ;
        endcase
    end

    // Requesters drop enable combinationally on their ack, so only a drop before the ack is a violation.
    assign w_drop = !mem_ack_i &&
                    ((r_state == ST_GNT0 && !p0_enable_i) || (r_state == ST_GNT1 && !p1_enable_i));

    always_ff @(posedge clk_i) begin
        if (!rst_i)      r_err <= 1'b0;
        else if (w_drop) r_err <= 1'b1;
    end

    assign err_o     = r_err;
    assign p0_data_o = mem_data_i;
    assign p1_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a memory model that acks 10 cycles after enable rises.
module tb_mem_arbiter;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              p0_enable_i = 1'b0, p0_write_i = 1'b0;
    logic [ADDR_W-1:0] p0_addr_i = '0;
    logic [DATA_W-1:0] p0_data_i = '0;
    logic              p0_ack_o;
    logic [DATA_W-1:0] p0_data_o;
    logic              p1_enable_i = 1'b0, p1_write_i = 1'b0;
    logic [ADDR_W-1:0] p1_addr_i = '0;
    logic [DATA_W-1:0] p1_data_i = '0;
    logic              p1_ack_o;
    logic [DATA_W-1:0] p1_data_o;
    logic              mem_enable_o, mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_ack_i = 1'b0;
    logic [DATA_W-1:0] mem_data_i = '0;
    logic [1:0]        gnt_o;
    logic              err_o;

    int n_cmp = 0;
    int n_err = 0;
    bit model_on = 1'b1;
    int model_cnt = 0;

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
        .p0_data_i(p0_data_i), .p0_ack_o(p0_ack_o), .p0_data_o(p0_data_o),
        .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
        .p1_data_i(p1_data_i), .p1_ack_o(p1_ack_o), .p1_data_o(p1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .gnt_o(gnt_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: one-cycle ack on the 10th falling edge that sees enable high; read data is the address replicated.
    always @(negedge clk_i) begin
        if (model_on) begin
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                model_cnt = 0;
            end else if (mem_enable_o) begin
                model_cnt = model_cnt + 1;
                if (model_cnt == 10) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = {8{mem_addr_o}};
                end
            end else begin
                model_cnt = 0;
            end
        end
    end

    task automatic step();
        @(negedge clk_i);
        #2;
    endtask

    // Waits (bounded) for an ack on the given port; flags any ack on the other port or an illegal grant.
    task automatic wait_ack(input int port, output bit ok, output bit other, output int cycles);
        ok = 1'b0; other = 1'b0; cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cycles++;
            if ((port == 0 ? p1_ack_o : p0_ack_o) || gnt_o == 2'b11) other = 1'b1;
            if (port == 0 ? p0_ack_o : p1_ack_o) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        p0_enable_i = 1'b0; p0_write_i = 1'b0; p0_addr_i = '0; p0_data_i = '0;
        p1_enable_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
        step();
        step();
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (mem_enable_o !== 1'b0) begin n_err++; $display("FAIL reset_enable: got %b want 0", mem_enable_o); end
        n_cmp++; if (gnt_o !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_o); end
        n_cmp++; if ({p1_ack_o, p0_ack_o, mem_write_o} !== 3'b000 || mem_addr_o !== '0)
            begin n_err++; $display("FAIL reset_outs: acks/write %b%b%b addr %h want all 0", p1_ack_o, p0_ack_o, mem_write_o, mem_addr_o); end
    endtask

    task automatic test_single_read();
        bit ok, other; int cyc;
        do_reset();
        p0_addr_i = 32'h40; p0_write_i = 1'b0; p0_enable_i = 1'b1;
        step();
        n_cmp++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL t1_gnt: got %b want 01", gnt_o); end
        n_cmp++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h40)
            begin n_err++; $display("FAIL t1_req: en %b wr %b addr %h want 1 0 00000040", mem_enable_o, mem_write_o, mem_addr_o); end
        wait_ack(0, ok, other, cyc);
        n_cmp++; if (!ok || cyc != 9) begin n_err++; $display("FAIL t1_ack: ok %b after %0d cycles want 1 after 9", ok, cyc); end
        n_cmp++; if (other || p1_ack_o !== 1'b0) begin n_err++; $display("FAIL t1_p1ack: stray p1 ack %b want 0", other); end
        n_cmp++; if (p0_data_o !== {8{32'h40}}) begin n_err++; $display("FAIL t1_data: got %h want replicated 00000040", p0_data_o); end
        p0_enable_i = 1'b0;
        step();
        n_cmp++; if (mem_enable_o !== 1'b0 || gnt_o !== 2'b00) begin n_err++; $display("FAIL t1_idle: en %b gnt %b want 0 00", mem_enable_o, gnt_o); end
    endtask

    task automatic test_both_fixed();
        bit ok, other; int cyc;
        do_reset();
        p0_addr_i = 32'h100; p1_addr_i = 32'h200;
        p0_enable_i = 1'b1; p1_enable_i = 1'b1;
        step();
        n_cmp++; if (gnt_o !== 2'b10 || mem_addr_o !== 32'h200) begin n_err++; $display("FAIL t2_first: gnt %b addr %h want 10 00000200", gnt_o, mem_addr_o); end
        wait_ack(1, ok, other, cyc);
        n_cmp++; if (!ok || other) begin n_err++; $display("FAIL t2_p1ack: ok %b overlap %b want 1 0", ok, other); end
        p1_enable_i = 1'b0;
        step();
        n_cmp++; if (gnt_o !== 2'b00 || mem_enable_o !== 1'b0) begin n_err++; $display("FAIL t2_gap: gnt %b en %b want 00 0", gnt_o, mem_enable_o); end
        step();
        n_cmp++; if (gnt_o !== 2'b01 || mem_addr_o !== 32'h100) begin n_err++; $display("FAIL t2_second: gnt %b addr %h want 01 00000100", gnt_o, mem_addr_o); end
        wait_ack(0, ok, other, cyc);
        n_cmp++; if (!ok || other) begin n_err++; $display("FAIL t2_p0ack: ok %b overlap %b want 1 0", ok, other); end
        p0_enable_i = 1'b0;
        step();
    endtask

    task automatic test_arb_order();
        bit ok, other; int cyc;
        logic [1:0] exp_g;
        do_reset();
        p0_enable_i = 1'b1; p1_enable_i = 1'b1;
        for (int t = 0; t < 6; t++) begin
`ifdef MEM_ARB_RR_EN
            exp_g = (t % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b10;
`endif
            for (int i = 0; i < 5 && gnt_o == 2'b00; i++) step();
            n_cmp++; if (gnt_o !== exp_g) begin n_err++; $display("FAIL t3_order[%0d]: got %b want %b", t, gnt_o, exp_g); end
            wait_ack(exp_g == 2'b10 ? 1 : 0, ok, other, cyc);
            n_cmp++; if (!ok || other) begin n_err++; $display("FAIL t3_ack[%0d]: ok %b overlap %b want 1 0", t, ok, other); end
            step();
        end
        p0_enable_i = 1'b0; p1_enable_i = 1'b0;
        step();
    endtask

    task automatic test_write_holdoff();
        bit ok, other; int cyc;
        do_reset();
        p1_addr_i = 32'h80; p1_write_i = 1'b1; p1_data_i = {32{8'hA5}}; p1_enable_i = 1'b1;
        step();
        n_cmp++; if (mem_write_o !== 1'b1 || mem_addr_o !== 32'h80) begin n_err++; $display("FAIL t4_wr: wr %b addr %h want 1 00000080", mem_write_o, mem_addr_o); end
        n_cmp++; if (mem_data_o !== {32{8'hA5}}) begin n_err++; $display("FAIL t4_wdata: got %h want A5 pattern", mem_data_o); end
        step();
        step();
        p0_addr_i = 32'h140; p0_write_i = 1'b0; p0_enable_i = 1'b1;
        wait_ack(1, ok, other, cyc);
        n_cmp++; if (!ok || other) begin n_err++; $display("FAIL t4_holdoff: p1 ok %b p0 early ack %b want 1 0", ok, other); end
        p1_enable_i = 1'b0; p1_write_i = 1'b0;
        step();
        step();
        n_cmp++; if (gnt_o !== 2'b01 || mem_addr_o !== 32'h140 || mem_write_o !== 1'b0)
            begin n_err++; $display("FAIL t4_next: gnt %b addr %h wr %b want 01 00000140 0", gnt_o, mem_addr_o, mem_write_o); end
        wait_ack(0, ok, other, cyc);
        n_cmp++; if (!ok || err_o !== 1'b0) begin n_err++; $display("FAIL t4_p0done: ok %b err %b want 1 0", ok, err_o); end
        p0_enable_i = 1'b0;
        step();
    endtask

    task automatic test_early_drop();
        bit ok, other; int cyc;
        do_reset();
        p0_addr_i = 32'h1C0; p0_enable_i = 1'b1;
        step();
        step();
        step();
        p0_enable_i = 1'b0;
        step();
        n_cmp++; if (mem_enable_o !== 1'b1 || gnt_o !== 2'b01) begin n_err++; $display("FAIL t5_hold: en %b gnt %b want 1 01", mem_enable_o, gnt_o); end
        wait_ack(0, ok, other, cyc);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL t5_ack: p0 ack seen %b want 1", ok); end
        n_cmp++; if (err_o !== 1'b1) begin n_err++; $display("FAIL t5_err: got %b want 1", err_o); end
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (err_o !== 1'b1) begin n_err++; $display("FAIL t5_sticky: got %b want 1", err_o); end
    endtask

    task automatic test_reset_midflight();
        bit ok, other; int cyc;
        p1_addr_i = 32'h240; p1_enable_i = 1'b1;
        step();
        n_cmp++; if (gnt_o !== 2'b10) begin n_err++; $display("FAIL t6_gnt1: got %b want 10", gnt_o); end
        rst_i = 1'b0; p1_enable_i = 1'b0;
        step();
        n_cmp++; if (mem_enable_o !== 1'b0 || gnt_o !== 2'b00 || err_o !== 1'b0)
            begin n_err++; $display("FAIL t6_rst: en %b gnt %b err %b want 0 00 0", mem_enable_o, gnt_o, err_o); end
        rst_i = 1'b1;
        model_on = 1'b0;
        mem_ack_i = 1'b1;
        #1;
        n_cmp++; if (p0_ack_o !== 1'b0 || p1_ack_o !== 1'b0) begin n_err++; $display("FAIL t6_stale: acks %b%b want 00", p1_ack_o, p0_ack_o); end
        step();
        n_cmp++; if (gnt_o !== 2'b00 || mem_enable_o !== 1'b0 || err_o !== 1'b0)
            begin n_err++; $display("FAIL t6_ignore: gnt %b en %b err %b want 00 0 0", gnt_o, mem_enable_o, err_o); end
        mem_ack_i = 1'b0;
        model_cnt = 0;
        model_on = 1'b1;
        p0_addr_i = 32'h300; p0_enable_i = 1'b1;
        step();
        n_cmp++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL t6_fresh_gnt: got %b want 01", gnt_o); end
        wait_ack(0, ok, other, cyc);
        n_cmp++; if (!ok || other || p0_data_o !== {8{32'h300}})
            begin n_err++; $display("FAIL t6_fresh: ok %b stray %b data %h want 1 0 replicated 00000300", ok, other, p0_data_o); end
        p0_enable_i = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_both_fixed();
        test_arb_order();
        test_write_holdoff();
        test_early_drop();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
